// File: rtl/n64adv2_apu_gain_sched.sv
`timescale 1ns/1ps
// Gain controller and scheduler for the APU amplification stage: one shared signed
// multiplier serves left and right, with click-free gain ramping and output saturation.
module n64adv2_apu_gain_sched #(
    parameter int GAIN_STEP = 1,
    parameter int RAMP_DIV  = 1
) (
    input  logic        MCLK_i,
    input  logic        nRST_i,
    input  logic [4:0]  amp_level_i,
    input  logic        mute_i,
    input  logic [23:0] pdata_left_i,
    input  logic [23:0] pdata_right_i,
    input  logic        pdata_valid_i,
    output logic        busy_o,
    output logic        overrun_o,
    output logic [8:0]  gain_o,
    output logic        ramp_active_o,
    output logic [23:0] pdata_left_o,
    output logic [23:0] pdata_right_o,
    output logic        pdata_valid_o
);

    typedef enum logic [1:0] {
        IDLE,
        MUL_L,
        MUL_R,
        OUT
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(RAMP_DIV - 1);
    localparam logic [8:0] STEP     = 9'(GAIN_STEP);

    state_t             state;
    logic [23:0]        left_q;
    logic [23:0]        right_q;
    logic [23:0]        hold_left;
    logic [8:0]         gain_pair;
    logic signed [32:0] prod;
    logic [7:0]         div_cnt;

    logic [8:0]         target;
    logic [8:0]         diff;
    logic [8:0]         stepped;
    logic               step_now;
    logic [8:0]         gain_next;
    logic signed [9:0]  mul_a;
    logic signed [23:0] mul_b;
    logic signed [32:0] mul_full;

    function automatic logic [8:0] gain_lut(input logic [4:0] idx);
        logic [8:0] g;
        case (idx)
            5'd0:  g = 9'd1;
            5'd1:  g = 9'd2;
            5'd2:  g = 9'd3;
            5'd3:  g = 9'd4;
            5'd4:  g = 9'd5;
            5'd5:  g = 9'd6;
            5'd6:  g = 9'd7;
            5'd7:  g = 9'd8;
            5'd8:  g = 9'd9;
            5'd9:  g = 9'd10;
            5'd10: g = 9'd11;
            5'd11: g = 9'd13;
            5'd12: g = 9'd14;
            5'd13: g = 9'd16;
            5'd14: g = 9'd18;
            5'd15: g = 9'd20;
            5'd16: g = 9'd23;
            5'd17: g = 9'd25;
            5'd18: g = 9'd29;
            5'd19: g = 9'd32;
            5'd20: g = 9'd36;
            5'd21: g = 9'd40;
            5'd22: g = 9'd45;
            5'd23: g = 9'd51;
            5'd24: g = 9'd57;
            5'd25: g = 9'd64;
            5'd26: g = 9'd72;
            5'd27: g = 9'd80;
            5'd28: g = 9'd90;
            5'd29: g = 9'd101;
            5'd30: g = 9'd114;
            default: g = 9'd127;
        endcase
        return g;
    endfunction

    // Product is gain * sample with unity at 32, so bits [28:5] carry the result.
    function automatic logic [23:0] sat24(input logic [32:0] p);
        logic [23:0] s;
        if (p[32] && (p[31:28] != 4'hF))
            s = 24'h800000;
        else if (!p[32] && (p[31:28] != 4'h0))
            s = 24'h7FFFFF;
        else
            s = p[28:5];
        return s;
    endfunction

    // Ramp step toward the target, clamped so it can never overshoot.
    always_comb begin
        target   = mute_i ? 9'd0 : gain_lut(amp_level_i);
        step_now = (div_cnt == DIV_LAST);
        diff     = 9'd0;
        stepped  = gain_o;
        if (target > gain_o) begin
            diff    = target - gain_o;
            stepped = (diff > STEP) ? (gain_o + STEP) : target;
        end else if (target < gain_o) begin
            diff    = gain_o - target;
            stepped = (diff > STEP) ? (gain_o - STEP) : target;
        end
        gain_next = step_now ? stepped : gain_o;
    end

    // Single shared multiplier; the gain is zero-extended so it is always positive.
    always_comb begin
        mul_a    = $signed({1'b0, gain_pair});
        mul_b    = (state == MUL_L) ? $signed(left_q) : $signed(right_q);
        mul_full = 33'(mul_a) * 33'(mul_b);
    end

    always_ff @(posedge MCLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            state         <= IDLE;
            left_q        <= 24'd0;
            right_q       <= 24'd0;
            hold_left     <= 24'd0;
            gain_pair     <= 9'd0;
            prod          <= 33'sd0;
            div_cnt       <= 8'd0;
            busy_o        <= 1'b0;
            overrun_o     <= 1'b0;
            gain_o        <= 9'd0;
            ramp_active_o <= 1'b0;
            pdata_left_o  <= 24'd0;
            pdata_right_o <= 24'd0;
            pdata_valid_o <= 1'b0;
        end else begin
            pdata_valid_o <= 1'b0;
            overrun_o     <= (state != IDLE) && pdata_valid_i;
            case (state)
                IDLE: begin
                    if (pdata_valid_i) begin
                        left_q        <= pdata_left_i;
                        right_q       <= pdata_right_i;
                        gain_pair     <= gain_o;
                        gain_o        <= gain_next;
                        div_cnt       <= step_now ? 8'd0 : 8'(div_cnt + 8'd1);
                        ramp_active_o <= (gain_next != target);
                        busy_o        <= 1'b1;
                        state         <= MUL_L;
                    end else begin
                        ramp_active_o <= (gain_o != target);
                    end
                end
                MUL_L: begin
                    prod  <= mul_full;
                    state <= MUL_R;
                end
                MUL_R: begin
                    prod      <= mul_full;
                    hold_left <= sat24(prod);
                    state     <= OUT;
                end
                OUT: begin
                    pdata_left_o  <= hold_left;
                    pdata_right_o <= sat24(prod);
                    pdata_valid_o <= 1'b1;
                    busy_o        <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_n64adv2_apu_gain_sched.sv
`timescale 1ns/1ps
// Bench for n64adv2_apu_gain_sched: three parameterisations share one stimulus stream,
// an arithmetic model predicts every output each cycle, directed literals pin the model.
module tb_n64adv2_apu_gain_sched;

    localparam int N = 3;

    logic        MCLK_i = 1'b0;
    logic        nRST_i = 1'b1;
    logic [4:0]  amp_level_i = 5'd0;
    logic        mute_i = 1'b0;
    logic [23:0] pdata_left_i = 24'd0;
    logic [23:0] pdata_right_i = 24'd0;
    logic        pdata_valid_i = 1'b0;

    logic        busy_w [N];
    logic        ovr_w  [N];
    logic        ramp_w [N];
    logic        vout_w [N];
    logic [8:0]  gain_w [N];
    logic [23:0] lo_w   [N];
    logic [23:0] ro_w   [N];

    int passCnt = 0;
    int totalCnt = 0;
    bit cmpOn = 1'b0;

    always #5 MCLK_i = ~MCLK_i;

    n64adv2_apu_gain_sched #(.GAIN_STEP(1), .RAMP_DIV(1)) dut0 (
        .MCLK_i(MCLK_i), .nRST_i(nRST_i), .amp_level_i(amp_level_i), .mute_i(mute_i),
        .pdata_left_i(pdata_left_i), .pdata_right_i(pdata_right_i), .pdata_valid_i(pdata_valid_i),
        .busy_o(busy_w[0]), .overrun_o(ovr_w[0]), .gain_o(gain_w[0]), .ramp_active_o(ramp_w[0]),
        .pdata_left_o(lo_w[0]), .pdata_right_o(ro_w[0]), .pdata_valid_o(vout_w[0]));

    n64adv2_apu_gain_sched #(.GAIN_STEP(4), .RAMP_DIV(1)) dut1 (
        .MCLK_i(MCLK_i), .nRST_i(nRST_i), .amp_level_i(amp_level_i), .mute_i(mute_i),
        .pdata_left_i(pdata_left_i), .pdata_right_i(pdata_right_i), .pdata_valid_i(pdata_valid_i),
        .busy_o(busy_w[1]), .overrun_o(ovr_w[1]), .gain_o(gain_w[1]), .ramp_active_o(ramp_w[1]),
        .pdata_left_o(lo_w[1]), .pdata_right_o(ro_w[1]), .pdata_valid_o(vout_w[1]));

    n64adv2_apu_gain_sched #(.GAIN_STEP(127), .RAMP_DIV(3)) dut2 (
        .MCLK_i(MCLK_i), .nRST_i(nRST_i), .amp_level_i(amp_level_i), .mute_i(mute_i),
        .pdata_left_i(pdata_left_i), .pdata_right_i(pdata_right_i), .pdata_valid_i(pdata_valid_i),
        .busy_o(busy_w[2]), .overrun_o(ovr_w[2]), .gain_o(gain_w[2]), .ramp_active_o(ramp_w[2]),
        .pdata_left_o(lo_w[2]), .pdata_right_o(ro_w[2]), .pdata_valid_o(vout_w[2]));

    int gainTable [32] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 14, 16, 18, 20,
                           23, 25, 29, 32, 36, 40, 45, 51, 57, 64, 72, 80, 90, 101, 114, 127};

    function automatic int stepOf(int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 127;
    endfunction

    function automatic int divOf(int k);
        return (k == 2) ? 3 : 1;
    endfunction

    // Output = floor(gain * sample / 32), clamped to the signed 24-bit range.
    function automatic logic [23:0] modelOut(int g, logic [23:0] s);
        longint p;
        longint q;
        p = longint'(g) * longint'($signed(s));
        q = p >>> 5;
        if (q > 64'sd8388607) return 24'h7FFFFF;
        if (q < -64'sd8388608) return 24'h800000;
        return 24'(q);
    endfunction

    task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                               input logic [31:0] exp);
        totalCnt++;
        if (act === exp)
            passCnt++;
        else
            $display("[TB] FAIL %s[%0d] at %0t: actual=%h required=%h", name, idx, $time, act, exp);
    endtask

    int cyc = 0;
    int acc = -100;
    int mgain [N];
    int mdiv  [N];
    int mgpair[N];
    logic [23:0] mL, mR;
    logic eBusy, eOvr, eValid;
    logic [8:0]  eGain [N];
    logic        eRamp [N];
    logic [23:0] eLo   [N];
    logic [23:0] eRo   [N];

    // Model: acceptance is tracked by the edge index of the last accepted strobe.
    always @(posedge MCLK_i or negedge nRST_i) begin
        int tgt;
        int diff;
        bit busyBefore;
        if (!nRST_i) begin
            acc = -100;
            eBusy = 1'b0; eOvr = 1'b0; eValid = 1'b0;
            for (int k = 0; k < N; k++) begin
                mgain[k] = 0; mdiv[k] = 0; mgpair[k] = 0;
                eGain[k] = 9'd0; eRamp[k] = 1'b0; eLo[k] = 24'd0; eRo[k] = 24'd0;
            end
        end else begin
            cyc++;
            tgt = mute_i ? 0 : gainTable[amp_level_i];
            busyBefore = ((cyc - 1 - acc) >= 0) && ((cyc - 1 - acc) <= 2);
            eOvr = pdata_valid_i && busyBefore;
            if (pdata_valid_i && !busyBefore) begin
                acc = cyc;
                mL = pdata_left_i;
                mR = pdata_right_i;
                for (int k = 0; k < N; k++) begin
                    mgpair[k] = mgain[k];
                    mdiv[k]++;
                    if (mdiv[k] == divOf(k)) begin
                        mdiv[k] = 0;
                        diff = tgt - mgain[k];
                        if (diff > 0) mgain[k] += (diff < stepOf(k)) ? diff : stepOf(k);
                        else if (diff < 0) mgain[k] -= (-diff < stepOf(k)) ? -diff : stepOf(k);
                    end
                    eRamp[k] = (mgain[k] != tgt);
                end
            end else if (!busyBefore) begin
                for (int k = 0; k < N; k++) eRamp[k] = (mgain[k] != tgt);
            end
            eBusy = ((cyc - acc) >= 0) && ((cyc - acc) <= 2);
            eValid = (cyc - acc) == 3;
            for (int k = 0; k < N; k++) begin
                eGain[k] = 9'(mgain[k]);
                if (eValid) begin
                    eLo[k] = modelOut(mgpair[k], mL);
                    eRo[k] = modelOut(mgpair[k], mR);
                end
            end
        end
    end

    always @(negedge MCLK_i) begin
        if (cmpOn) begin
            for (int k = 0; k < N; k++) begin
                checkOutput("busy", k, 32'(busy_w[k]), 32'(eBusy));
                checkOutput("overrun", k, 32'(ovr_w[k]), 32'(eOvr));
                checkOutput("valid", k, 32'(vout_w[k]), 32'(eValid));
                checkOutput("gain", k, 32'(gain_w[k]), 32'(eGain[k]));
                checkOutput("ramp", k, 32'(ramp_w[k]), 32'(eRamp[k]));
                checkOutput("left", k, 32'(lo_w[k]), 32'(eLo[k]));
                checkOutput("right", k, 32'(ro_w[k]), 32'(eRo[k]));
            end
        end
    end

    // One accepted pair; returns just after the edge that should raise the output strobe.
    task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r);
        @(negedge MCLK_i);
        pdata_left_i = l;
        pdata_right_i = r;
        pdata_valid_i = 1'b1;
        @(posedge MCLK_i);
        @(negedge MCLK_i);
        pdata_valid_i = 1'b0;
        @(posedge MCLK_i);
        @(posedge MCLK_i);
        #1 checkOutput("valid_pre", 0, 32'(vout_w[0]), 32'd0);
        @(posedge MCLK_i);
        #1 checkOutput("valid_t3", 0, 32'(vout_w[0]), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge MCLK_i);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #3 nRST_i = 1'b0;
        #1 cmpOn = 1'b1;
        checkOutput("rst_gain", 0, 32'(gain_w[0]), 32'd0);
        checkOutput("rst_busy", 0, 32'(busy_w[0]), 32'd0);
        checkOutput("rst_left", 0, 32'(lo_w[0]), 32'd0);
        checkOutput("rst_valid", 0, 32'(vout_w[0]), 32'd0);
        repeat (3) @(negedge MCLK_i);
        nRST_i = 1'b1;
        amp_level_i = 5'd19;
        mute_i = 1'b0;
        idle(3);

        applyStimulus(24'h00001F, 24'h000040);
        checkOutput("gain0_left", 0, 32'(lo_w[0]), 32'd0);
        applyStimulus(24'h00001F, 24'h000040);
        checkOutput("trunc_left", 0, 32'(lo_w[0]), 32'd0);
        checkOutput("trunc_right", 0, 32'(ro_w[0]), 32'd2);
        idle(12);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(24'h123456, 24'hFEDCBA);
            checkOutput("ramp_gain", 0, 32'(gain_w[0]), (i + 3 < 32) ? 32'(i + 3) : 32'd32);
            checkOutput("ramp_flag", 0, 32'(ramp_w[0]), (i + 3 < 32) ? 32'd1 : 32'd0);
            idle(12);
        end
        checkOutput("unity_left", 0, 32'(lo_w[0]), 32'h123456);
        checkOutput("unity_right", 0, 32'(ro_w[0]), 32'hFEDCBA);

        applyStimulus(24'h000000, 24'hFFFFFF);
        checkOutput("minus1_right", 0, 32'(ro_w[0]), 32'hFFFFFF);
        idle(4);

        // Second strobe lands two edges after the first, while the pair is still in flight.
        @(negedge MCLK_i);
        pdata_left_i = 24'h000AAA;
        pdata_right_i = 24'h000555;
        pdata_valid_i = 1'b1;
        @(posedge MCLK_i);
        @(negedge MCLK_i);
        pdata_valid_i = 1'b0;
        @(negedge MCLK_i);
        pdata_left_i = 24'h7FFFFF;
        pdata_right_i = 24'h7FFFFF;
        pdata_valid_i = 1'b1;
        @(posedge MCLK_i);
        #1 checkOutput("ovr_pulse", 0, 32'(ovr_w[0]), 32'd1);
        checkOutput("ovr_novalid", 0, 32'(vout_w[0]), 32'd0);
        @(negedge MCLK_i);
        pdata_valid_i = 1'b0;
        @(posedge MCLK_i);
        #1 checkOutput("ovr_valid", 0, 32'(vout_w[0]), 32'd1);
        checkOutput("ovr_clear", 0, 32'(ovr_w[0]), 32'd0);
        checkOutput("ovr_left", 0, 32'(lo_w[0]), 32'h000AAA);
        checkOutput("ovr_right", 0, 32'(ro_w[0]), 32'h000555);
        @(posedge MCLK_i);
        #1 checkOutput("ovr_single", 0, 32'(vout_w[0]), 32'd0);
        idle(6);

        mute_i = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(24'h123456, 24'hFEDCBA);
            checkOutput("mute_gain", 1, 32'(gain_w[1]), (32 - 4 * i > 0) ? 32'(32 - 4 * i) : 32'd0);
            idle(2);
        end
        checkOutput("mute_left", 1, 32'(lo_w[1]), 32'd0);
        checkOutput("mute_right", 1, 32'(ro_w[1]), 32'd0);
        checkOutput("mute_ramp", 1, 32'(ramp_w[1]), 32'd0);
        mute_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(24'h123456, 24'hFEDCBA);
            idle(2);
        end
        checkOutput("unmute_gain", 1, 32'(gain_w[1]), 32'd12);
        checkOutput("unmute_ramp", 1, 32'(ramp_w[1]), 32'd1);

        amp_level_i = 5'd31;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(24'h000000, 24'h000000);
            idle(1);
        end
        applyStimulus(24'h400000, 24'hC00000);
        checkOutput("sat_gain", 2, 32'(gain_w[2]), 32'd127);
        checkOutput("sat_left", 2, 32'(lo_w[2]), 32'h7FFFFF);
        checkOutput("sat_right", 2, 32'(ro_w[2]), 32'h800000);
        idle(3);

        // Reset lands while the pair sits in MUL_R.
        @(negedge MCLK_i);
        pdata_left_i = 24'h111111;
        pdata_right_i = 24'h222222;
        pdata_valid_i = 1'b1;
        @(posedge MCLK_i);
        @(negedge MCLK_i);
        pdata_valid_i = 1'b0;
        @(posedge MCLK_i);
        #2 checkOutput("pre_rst_busy", 2, 32'(busy_w[2]), 32'd1);
        nRST_i = 1'b0;
        #1 checkOutput("mid_rst_left", 2, 32'(lo_w[2]), 32'd0);
        checkOutput("mid_rst_right", 2, 32'(ro_w[2]), 32'd0);
        checkOutput("mid_rst_gain", 2, 32'(gain_w[2]), 32'd0);
        checkOutput("mid_rst_busy", 2, 32'(busy_w[2]), 32'd0);
        repeat (3) @(negedge MCLK_i);
        nRST_i = 1'b1;
        idle(5);
        applyStimulus(24'h123456, 24'hFEDCBA);
        checkOutput("post_rst_gain0", 0, 32'(gain_w[0]), 32'd1);
        checkOutput("post_rst_gain2", 2, 32'(gain_w[2]), 32'd0);
        checkOutput("post_rst_left", 2, 32'(lo_w[2]), 32'd0);
        idle(6);

        cmpOn = 1'b0;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
